// File: rtl/op_seq_pkg.sv
// op_sequencer shared types.
// Request bundle, op encodings, FSM states.
package op_seq_pkg;

  localparam int W     = 4;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    OP_RCA,
    OP_ODDEVEN,
    OP_DIV4,
    OP_TWOCMP
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } seq_state_t;

  typedef struct packed {
    logic [W-1:0] a;
    op_t          op;
    logic         sweep;
  } req_t;

endpackage

// File: rtl/op_sequencer_fifo.sv
// Synchronous request FIFO with flush.
// full/empty derive from the registered count only.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rp];

  // Pointer and occupancy bookkeeping; flush empties in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/op_sequencer.sv
// Feeds queued requests to the external datapath
// and returns each captured result over valid/ready.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int DEPTH = op_seq_pkg::DEPTH,
  parameter int W     = op_seq_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [1:0]   req_op,
  input  logic         req_sweep,
  input  logic         abort,
  output logic [W-1:0] dp_a,
  output logic [1:0]   dp_sel,
  input  logic [W-1:0] dp_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_op,
  output logic         busy
);

  seq_state_t state, state_n;
  req_t       in_req, head;
  logic       full, empty, pop;
  logic [$clog2(DEPTH):0] count;

  logic [W-1:0] dp_a_n, res_data_n;
  logic [1:0]   dp_sel_n, res_op_n;
  logic         sweep_r, sweep_n, res_valid_n;

  assign in_req    = '{a: req_a, op: op_t'(req_op), sweep: req_sweep};
  assign req_ready = !full;
  assign busy      = (state != IDLE) || (count != '0);

  req_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(req_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (req_valid && !abort),
    .din   (in_req),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next-state, datapath drive and result capture decisions.
  always_comb begin
    state_n     = state;
    dp_a_n      = dp_a;
    dp_sel_n    = dp_sel;
    sweep_n     = sweep_r;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    res_op_n    = res_op;
    pop         = 1'b0;
    if (abort) begin
      state_n     = IDLE;
      res_valid_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            dp_a_n   = head.a;
            dp_sel_n = head.sweep ? 2'd0 : head.op;
            sweep_n  = head.sweep;
            state_n  = EXEC;
          end
        end
        EXEC: begin
          res_data_n  = dp_out;
          res_op_n    = dp_sel;
          res_valid_n = 1'b1;
          state_n     = HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_n = 1'b0;
            if (sweep_r && dp_sel != 2'd3) begin
              dp_sel_n = dp_sel + 2'd1;
              state_n  = EXEC;
            end else if (!empty) begin
              pop      = 1'b1;
              dp_a_n   = head.a;
              dp_sel_n = head.sweep ? 2'd0 : head.op;
              sweep_n  = head.sweep;
              state_n  = EXEC;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dp_a      <= '0;
      dp_sel    <= '0;
      sweep_r   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else begin
      state     <= state_n;
      dp_a      <= dp_a_n;
      dp_sel    <= dp_sel_n;
      sweep_r   <= sweep_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_op    <= res_op_n;
    end
  end

endmodule
